// File: rtl/reimu_bullet.sv
// reimu_bullet: player shot pool - spawns upward bullets, advances them per tick,
// despawns at the playfield top and hit-tests four enemies. Build macro: DUAL_SHOT_EN.
module reimu_bullet #(
  parameter int NUM_BULLETS = 4,
  parameter int SPEED       = 12,
  parameter int COOLDOWN    = 3,
  parameter int HIT_R       = 12,
  parameter int Y_TOP       = 8
) (
  input  logic                      clk22,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      fire,
  input  logic [9:0]                reimux,
  input  logic [9:0]                reimuy,
  input  logic [9:0]                enmx1,
  input  logic [9:0]                enmx2,
  input  logic [9:0]                enmx3,
  input  logic [9:0]                enmx4,
  input  logic [9:0]                enmy1,
  input  logic [9:0]                enmy2,
  input  logic [9:0]                enmy3,
  input  logic [9:0]                enmy4,
  input  logic [6:0]                enmhp1,
  input  logic [6:0]                enmhp2,
  input  logic [6:0]                enmhp3,
  input  logic [6:0]                enmhp4,
  output logic [NUM_BULLETS*10-1:0] bullet_x,
  output logic [NUM_BULLETS*10-1:0] bullet_y,
  output logic [NUM_BULLETS-1:0]    bullet_vld,
  output logic [3:0]                hit
);
  localparam int          IW        = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int          CW        = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [10:0] TOP_LIM   = 11'(Y_TOP + SPEED);
  localparam logic [10:0] SPAWN_MIN = 11'(Y_TOP + 12);
  localparam logic [10:0] HR        = 11'(HIT_R);
  localparam logic [9:0]  SPD       = 10'(SPEED);
  localparam logic [9:0]  SPAWN_DY  = 10'd12;

  logic [9:0]             bx_q [NUM_BULLETS];
  logic [9:0]             by_q [NUM_BULLETS];
  logic [9:0]             bx_d [NUM_BULLETS];
  logic [9:0]             by_d [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] vld_q, vld_d;
  logic [3:0]             hit_q, hit_d;
  logic [CW-1:0]          cd_q, cd_d;

  logic [9:0] ex [4];
  logic [9:0] ey [4];
  logic [6:0] ehp [4];

  assign ex[0] = enmx1;  assign ex[1] = enmx2;  assign ex[2] = enmx3;  assign ex[3] = enmx4;
  assign ey[0] = enmy1;  assign ey[1] = enmy2;  assign ey[2] = enmy3;  assign ey[3] = enmy4;
  assign ehp[0] = enmhp1; assign ehp[1] = enmhp2; assign ehp[2] = enmhp3; assign ehp[3] = enmhp4;

  logic          slot_hit;
  logic          accept;
  logic [IW-1:0] free0;
  logic          free0_ok;
`ifdef DUAL_SHOT_EN
  logic [IW-1:0] free1;
  logic          free1_ok;
`endif

  always_comb begin
    hit_d    = '0;
    vld_d    = vld_q;
    cd_d     = (cd_q != '0) ? cd_q - CW'(1) : '0;
    slot_hit = 1'b0;
    accept   = 1'b0;
    free0    = '0;
    free0_ok = 1'b0;
`ifdef DUAL_SHOT_EN
    free1    = '0;
    free1_ok = 1'b0;
`endif
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bx_d[i] = bx_q[i];
      by_d[i] = by_q[i];
    end

    // Slot update: hit beats top-despawn beats move; lowest enemy index wins.
    for (int i = 0; i < NUM_BULLETS; i++) begin
      slot_hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!slot_hit && vld_q[i] && (ehp[k] != '0) &&
            ({1'b0, bx_q[i]} + HR > {1'b0, ex[k]}) && ({1'b0, bx_q[i]} < {1'b0, ex[k]} + HR) &&
            ({1'b0, by_q[i]} + HR > {1'b0, ey[k]}) && ({1'b0, by_q[i]} < {1'b0, ey[k]} + HR)) begin
          slot_hit = 1'b1;
          hit_d[k] = 1'b1;
        end
      end
      if (slot_hit || (vld_q[i] && ({1'b0, by_q[i]} < TOP_LIM))) begin
        vld_d[i] = 1'b0;
        bx_d[i]  = '0;
        by_d[i]  = '0;
      end else if (vld_q[i]) begin
        by_d[i] = by_q[i] - SPD;
      end
    end

    // Free slots come from the registered state, so a slot retired this tick waits a tick.
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!vld_q[i]) begin
        if (!free0_ok) begin
          free0    = IW'(i);
          free0_ok = 1'b1;
        end
`ifdef DUAL_SHOT_EN
        else if (!free1_ok) begin
          free1    = IW'(i);
          free1_ok = 1'b1;
        end
`endif
      end
    end

`ifdef DUAL_SHOT_EN
    accept = fire && (cd_q == '0) && free0_ok && free1_ok &&
             ({1'b0, reimuy} >= SPAWN_MIN) && (reimux >= 10'd6);
    if (accept) begin
      vld_d[free0] = 1'b1;
      bx_d[free0]  = reimux - 10'd6;
      by_d[free0]  = reimuy - SPAWN_DY;
      vld_d[free1] = 1'b1;
      bx_d[free1]  = reimux + 10'd6;
      by_d[free1]  = reimuy - SPAWN_DY;
      cd_d         = CW'(COOLDOWN);
    end
`else
    accept = fire && (cd_q == '0) && free0_ok && ({1'b0, reimuy} >= SPAWN_MIN);
    if (accept) begin
      vld_d[free0] = 1'b1;
      bx_d[free0]  = reimux;
      by_d[free0]  = reimuy - SPAWN_DY;
      cd_d         = CW'(COOLDOWN);
    end
`endif

    if (clear) begin
      hit_d = '0;
      vld_d = '0;
      cd_d  = '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        bx_d[i] = '0;
        by_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk22 or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      hit_q <= '0;
      cd_q  <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        bx_q[i] <= '0;
        by_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      hit_q <= hit_d;
      cd_q  <= cd_d;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        bx_q[i] <= bx_d[i];
        by_q[i] <= by_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_pack
    assign bullet_x[g*10 +: 10] = bx_q[g];
    assign bullet_y[g*10 +: 10] = by_q[g];
  end
  assign bullet_vld = vld_q;
  assign hit        = hit_q;

endmodule

// File: tb/tb_reimu_bullet.sv
// Bench for reimu_bullet: randomized stimulus, a slot-level reference model feeding a
// scoreboard queue, and a monitor comparing every registered output beat.
module tb_reimu_bullet;
  localparam int NB       = 4;
  localparam int SPEED    = 12;
  localparam int COOLDOWN = 3;
  localparam int HIT_R    = 12;
  localparam int Y_TOP    = 8;

  typedef struct {
    logic [NB-1:0]    vld;
    logic [NB*10-1:0] x;
    logic [NB*10-1:0] y;
    logic [3:0]       hit;
  } exp_t;

  logic             clk22 = 1'b0;
  logic             rst_n = 1'b1;
  logic             clear = 1'b0;
  logic             fire  = 1'b0;
  logic [9:0]       reimux = '0;
  logic [9:0]       reimuy = '0;
  logic [9:0]       enmx [4];
  logic [9:0]       enmy [4];
  logic [6:0]       enmhp [4];
  logic [NB*10-1:0] bullet_x, bullet_y;
  logic [NB-1:0]    bullet_vld;
  logic [3:0]       hit;

  int   vectors = 0;
  int   errs    = 0;
  exp_t sb [$];

  int m_vld [NB];
  int m_x   [NB];
  int m_y   [NB];
  int m_cd;

  always #5 clk22 = ~clk22;

  reimu_bullet #(
    .NUM_BULLETS(NB), .SPEED(SPEED), .COOLDOWN(COOLDOWN), .HIT_R(HIT_R), .Y_TOP(Y_TOP)
  ) dut (
    .clk22(clk22), .rst_n(rst_n), .clear(clear), .fire(fire),
    .reimux(reimux), .reimuy(reimuy),
    .enmx1(enmx[0]), .enmx2(enmx[1]), .enmx3(enmx[2]), .enmx4(enmx[3]),
    .enmy1(enmy[0]), .enmy2(enmy[1]), .enmy3(enmy[2]), .enmy4(enmy[3]),
    .enmhp1(enmhp[0]), .enmhp2(enmhp[1]), .enmhp3(enmhp[2]), .enmhp4(enmhp[3]),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_vld(bullet_vld), .hit(hit)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NB; s++) begin
      m_vld[s] = 0; m_x[s] = 0; m_y[s] = 0;
    end
    m_cd = 0;
  endtask

  // One game tick of the shot rules, using the inputs currently driven.
  task automatic model_step();
    int   nhit;
    int   freeq [$];
    bit   ok;
    exp_t e;
    nhit = 0;
    if (clear) begin
      model_reset();
    end else begin
      for (int s = 0; s < NB; s++) begin
        if (m_vld[s] != 0) begin
          int hk;
          hk = -1;
          for (int k = 0; k < 4; k++)
            if (hk < 0 && enmhp[k] != 0 &&
                m_x[s] + HIT_R > int'(enmx[k]) && m_x[s] < int'(enmx[k]) + HIT_R &&
                m_y[s] + HIT_R > int'(enmy[k]) && m_y[s] < int'(enmy[k]) + HIT_R)
              hk = k;
          if (hk >= 0) begin
            nhit = nhit | (1 << hk);
            m_vld[s] = 0; m_x[s] = 0; m_y[s] = 0;
          end else if (m_y[s] < Y_TOP + SPEED) begin
            m_vld[s] = 0; m_x[s] = 0; m_y[s] = 0;
          end else begin
            m_y[s] = m_y[s] - SPEED;
          end
        end else begin
          freeq.push_back(s);
        end
      end
      ok = fire && m_cd == 0 && int'(reimuy) >= Y_TOP + 12;
      m_cd = (m_cd > 0) ? m_cd - 1 : 0;
`ifdef DUAL_SHOT_EN
      ok = ok && freeq.size() >= 2 && int'(reimux) >= 6;
      if (ok) begin
        m_vld[freeq[0]] = 1; m_x[freeq[0]] = int'(reimux) - 6;
        m_y[freeq[0]] = int'(reimuy) - 12;
        m_vld[freeq[1]] = 1; m_x[freeq[1]] = (int'(reimux) + 6) % 1024;
        m_y[freeq[1]] = int'(reimuy) - 12;
        m_cd = COOLDOWN;
      end
`else
      ok = ok && freeq.size() >= 1;
      if (ok) begin
        m_vld[freeq[0]] = 1; m_x[freeq[0]] = int'(reimux);
        m_y[freeq[0]] = int'(reimuy) - 12;
        m_cd = COOLDOWN;
      end
`endif
    end
    for (int s = 0; s < NB; s++) begin
      e.vld[s]       = (m_vld[s] != 0);
      e.x[s*10 +: 10] = 10'(m_x[s]);
      e.y[s*10 +: 10] = 10'(m_y[s]);
    end
    e.hit = 4'(nhit);
    sb.push_back(e);
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic tick();
    model_step();
    @(negedge clk22);
  endtask

  task automatic set_enemies_off();
    for (int k = 0; k < 4; k++) begin
      enmx[k] = 10'd900; enmy[k] = 10'd900; enmhp[k] = 7'd0;
    end
  endtask

  task automatic rand_enemies();
    for (int k = 0; k < 4; k++) begin
      int v;
      v = int'(reimux) + int'($urandom_range(0, 60)) - 30;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      enmx[k]  = 10'(v);
      enmy[k]  = 10'($urandom_range(0, int'(reimuy)));
      enmhp[k] = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    fire  = 1'b1;
    tick();
    clear = 1'b0;
    fire  = 1'b0;
  endtask

  always begin
    exp_t e;
    @(posedge clk22);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("bullet_vld", 64'(bullet_vld), 64'(e.vld));
      check("bullet_x", 64'(bullet_x), 64'(e.x));
      check("bullet_y", 64'(bullet_y), 64'(e.y));
      check("hit", 64'(hit), 64'(e.hit));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1);
  end

  initial begin
    int nh;
    logic [3:0] hv;
    set_enemies_off();
    model_reset();

    // Power-up reset, checked without a clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_vld", 64'(bullet_vld), 64'd0);
    check("rst_x", 64'(bullet_x), 64'd0);
    check("rst_y", 64'(bullet_y), 64'd0);
    check("rst_hit", 64'(hit), 64'd0);
    @(negedge clk22);
    rst_n = 1'b1;

    // Held fire: first spawn, cooldown spacing, then async reset mid-flight.
    reimux = 10'd200; reimuy = 10'd400; fire = 1'b1;
    tick();
`ifdef DUAL_SHOT_EN
    check("spawn_x0", 64'(bullet_x[9:0]), 64'd194);
    check("spawn_x1", 64'(bullet_x[19:10]), 64'd206);
`else
    check("spawn_x0", 64'(bullet_x[9:0]), 64'd200);
    check("spawn_vld1", 64'(bullet_vld[1]), 64'd0);
`endif
    check("spawn_y0", 64'(bullet_y[9:0]), 64'd388);
    repeat (8) tick();
`ifdef DUAL_SHOT_EN
    check("held_count", 64'($countones(bullet_vld)), 64'd4);
`else
    check("held_count", 64'($countones(bullet_vld)), 64'd3);
`endif
    fire = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_vld", 64'(bullet_vld), 64'd0);
    check("midrst_x", 64'(bullet_x), 64'd0);
    check("midrst_y", 64'(bullet_y), 64'd0);
    check("midrst_hit", 64'(hit), 64'd0);
    model_reset();
    @(negedge clk22);
    rst_n = 1'b1;

    // Pool fills, stays full while held, reuses slots as the top retires them.
    reimux = 10'd300; reimuy = 10'd600; fire = 1'b1;
    repeat (70) tick();
    fire = 1'b0;

    // Live enemy in the bullet's path: one single-cycle pulse on hit[0].
    do_clear();
    enmx[0] = 10'd200; enmy[0] = 10'd340; enmhp[0] = 7'd5;
    reimux = 10'd200; reimuy = 10'd400; fire = 1'b1;
    tick();
    fire = 1'b0;
    nh = 0; hv = '0;
    repeat (12) begin
      tick();
      if (hit != 4'd0) begin
        nh++; hv = hit;
      end
    end
    check("hit_pulses", 64'(nh), 64'd1);
    check("hit_value", 64'(hv), 64'd1);
    check("hit_despawn", 64'(bullet_vld), 64'd0);

    // Same geometry, dead enemy: bullet flies through and retires at the top.
    do_clear();
    enmhp[0] = 7'd0;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    nh = 0;
    repeat (40) begin
      tick();
      if (hit != 4'd0) nh++;
    end
    check("dead_no_hit", 64'(nh), 64'd0);
    check("dead_despawn", 64'(bullet_vld), 64'd0);

    // Randomized play.
    rand_enemies();
    for (int t = 0; t < 1500; t++) begin
      fire  = ($urandom_range(0, 9) < 6);
      clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) begin
        reimux = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(0, 10)) : 10'($urandom_range(0, 1023));
        reimuy = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(0, 30)) : 10'($urandom_range(100, 1023));
      end
      if ($urandom_range(0, 29) == 0) rand_enemies();
      tick();
    end
    clear = 1'b0;
    fire  = 1'b0;

    repeat (2) @(posedge clk22);
    #2;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
